mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, range 1..255; cycles waited for mem_ack before the block aborts the transfer.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 inst_req  in  1  single-cycle instruction fetch request pulse.
REQ-005 inst_addr  in  32  fetch byte address, sampled with inst_req.
REQ-006 inst_ack  out  1  single-cycle fetch completion pulse.
REQ-007 inst_q  out  32  fetch data, valid while inst_ack=1.
REQ-008 data_req  in  1  single-cycle data access request pulse.
REQ-009 data_addr  in  32  data byte address, sampled with data_req.
REQ-010 data_data  in  32  write data, sampled with data_req.
REQ-011 data_wren  in  1  1=write, 0=read, sampled with data_req.
REQ-012 data_mask  in  4  byte enables, sampled with data_req.
REQ-013 data_ack  out  1  single-cycle data completion pulse.
REQ-014 data_q  out  32  read data, valid while data_ack=1.
REQ-015 mem_req  out  1  single-cycle request pulse to the shared memory port.
REQ-016 mem_addr/mem_data/mem_wren/mem_mask  out  32/32/1/4  granted transfer fields, held stable from mem_req until completion.
REQ-017 mem_ack  in  1  memory completion pulse.
REQ-018 mem_q  in  32  memory read data, valid with mem_ack.
REQ-019 bus_err  out  1  single-cycle pulse when a transfer times out.

Function
REQ-020 Each requester SHALL have one pending slot; a req pulse SHALL capture its fields into that slot regardless of arbiter state.
REQ-021 A req arriving while that requester's slot is already pending SHALL be ignored; the captured fields SHALL NOT change.
REQ-022 States SHALL be IDLE and WAIT; the block SHALL allow at most one outstanding memory transfer.
REQ-023 The IDLE arbitration inputs SHALL include a pending slot or a req pulse in the current cycle. In IDLE with at least one of these, the block SHALL assert mem_req for one cycle at the next edge and enter WAIT.
REQ-024 Arbitration SHALL be round-robin: when both requesters are eligible, the block SHALL grant the requester not granted last; after reset, data SHALL win the first tie.
REQ-025 An instruction grant SHALL drive mem_wren=0, mem_mask=4'hF and mem_data=0.
REQ-026 In WAIT, mem_ack SHALL complete the transfer: the owner's ack SHALL pulse at the next edge with q=mem_q (reads only), the owner's slot SHALL clear, and the state SHALL return to IDLE.
REQ-027 For a data write, data_q SHALL hold its previous value; data_ack SHALL still pulse.
REQ-028 The non-owner's q output SHALL hold its value during the other requester's completion.
REQ-029 Latency SHALL be as follows: req in cycle N with the block idle gives mem_req in N+1. mem_ack in cycle M gives the requester ack in M+1. The next grant SHALL be no earlier than M+2.
REQ-030 An 8-bit wait counter SHALL clear on grant and increment each WAIT cycle without mem_ack.
REQ-031 When the counter reaches TIMEOUT, the block SHALL complete the transfer at the next edge. The owner's ack SHALL pulse with q=32'hFFFF_FFFF for reads and bus_err=1, and the state SHALL return to IDLE.
REQ-032 mem_ack in IDLE SHALL be ignored.
REQ-033 If mem_ack and the timeout fall in the same cycle, mem_ack SHALL win; bus_err SHALL stay 0.
REQ-034 A req for the requester completing in the same cycle as its mem_ack SHALL be ignored, because its slot is still pending.
REQ-035 The ack outputs, mem_req and bus_err SHALL be registered and each SHALL be high for exactly one cycle per event.

Reset
REQ-036 Reset asserted SHALL immediately clear the state to IDLE, both slots, the counter and the round-robin pointer (data first). It SHALL also drive all outputs to 0, including q and mem fields.
REQ-037 A transfer in flight at reset SHALL NOT produce an ack after reset release; a stale mem_ack after release SHALL be ignored per REQ-032.

Verification
V1 Send inst_req, addr 0x100; memory acks one cycle after mem_req with mem_q 0x12345678. Required: mem_req at N+1, mem_addr 0x100 and mem_mask F; mem_ack at N+2; inst_ack and inst_q 0x12345678 at N+3.
V2 Send inst_req and data_req in the same cycle just after reset. Required: the data transfer is granted first and the inst transfer follows. A second simultaneous pair is then granted inst first.
V3 Send a data write to 0x8000_0000 with data 0x41 and mask 1, with data_q previously 0x55. Required: mem_wren=1, mem_mask=1, mem_data=0x41; data_ack pulses; data_q stays 0x55.
V4 Memory never acks and TIMEOUT=4. Required: 4 WAIT cycles, then data_ack with data_q FFFF_FFFF and a one-cycle bus_err pulse; a later mem_ack is ignored.
V5 Send a second inst_req while inst is pending. Required: exactly one mem_req and one inst_ack, carrying the first address.
V6 Assert reset during WAIT. Required: all outputs are 0 immediately, no ack occurs after release, and a new request after release completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between an instruction-fetch requester and a data
//   requester. Each requester has a single pending slot. A round-robin pointer
//   decides ties, and at most one memory transfer is outstanding at a time.
//   A transfer that waits TIMEOUT cycles without mem_ack is aborted. Reads then
//   return all-ones, and bus_err pulses.
// Ports
//   clk, reset                      clock, async active-high reset
//   inst_req/inst_addr              fetch request pulse + byte address
//   inst_ack/inst_q                 fetch completion pulse + data
//   data_req/addr/data/wren/mask    data request pulse + fields
//   data_ack/data_q                 data completion pulse + read data
//   mem_req/addr/data/wren/mask     granted transfer to shared port
//   mem_ack/mem_q                   memory completion pulse + read data
//   bus_err                         pulse on timeout abort
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ack,
  output logic [31:0] inst_q,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_data,
  input  logic        data_wren,
  input  logic [3:0]  data_mask,
  output logic        data_ack,
  output logic [31:0] data_q,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_wren,
  output logic [3:0]  mem_mask,
  input  logic        mem_ack,
  input  logic [31:0] mem_q,
  output logic        bus_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wren;
    logic [3:0]  mask;
  } xfer_t;

  // The counter starts at 0 on the grant edge. Completing when it shows
  // TIMEOUT-1 therefore gives exactly TIMEOUT WAIT cycles.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state;
  logic        inst_pend, data_pend;
  logic [31:0] inst_slot;
  xfer_t       data_slot;
  logic        inst_prio;   // 1: inst wins the next tie
  logic        owner_data;  // owner of the transfer in flight
  logic [7:0]  cnt;

  logic  inst_elig, data_elig, grant_data;
  xfer_t inst_x, data_x;

  // A request pulse in the current cycle is eligible before it lands in its
  // slot. Its fields come straight from the inputs in that case.
  always_comb begin
    inst_elig  = inst_pend | inst_req;
    data_elig  = data_pend | data_req;
    grant_data = data_elig & (~inst_elig | ~inst_prio);
    inst_x     = '{addr: inst_pend ? inst_slot : inst_addr,
                   data: 32'h0, wren: 1'b0, mask: 4'hF};
    data_x     = data_pend ? data_slot
                           : '{addr: data_addr, data: data_data,
                               wren: data_wren, mask: data_mask};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      inst_pend  <= 1'b0;
      data_pend  <= 1'b0;
      inst_slot  <= '0;
      data_slot  <= '0;
      inst_prio  <= 1'b0;
      owner_data <= 1'b0;
      cnt        <= '0;
      inst_ack   <= 1'b0;
      inst_q     <= '0;
      data_ack   <= 1'b0;
      data_q     <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_wren   <= 1'b0;
      mem_mask   <= '0;
      bus_err    <= 1'b0;
    end else begin
      inst_ack <= 1'b0;
      data_ack <= 1'b0;
      mem_req  <= 1'b0;
      bus_err  <= 1'b0;

      // A slot that is already pending ignores new pulses. This also covers
      // a pulse that arrives in the requester's own completion cycle.
      if (inst_req && !inst_pend) begin
        inst_pend <= 1'b1;
        inst_slot <= inst_addr;
      end
      if (data_req && !data_pend) begin
        data_pend <= 1'b1;
        data_slot <= '{addr: data_addr, data: data_data,
                       wren: data_wren, mask: data_mask};
      end

      case (state)
        S_IDLE: begin
          if (inst_elig || data_elig) begin
            mem_req    <= 1'b1;
            state      <= S_WAIT;
            cnt        <= '0;
            owner_data <= grant_data;
            inst_prio  <= grant_data;
            {mem_addr, mem_data, mem_wren, mem_mask} <= grant_data ? data_x : inst_x;
          end
        end
        S_WAIT: begin
          // mem_ack takes priority over a timeout that falls in the same cycle.
          if (mem_ack || cnt == LAST_CNT) begin
            state   <= S_IDLE;
            bus_err <= ~mem_ack;
            if (owner_data) begin
              data_ack  <= 1'b1;
              data_pend <= 1'b0;
              if (!mem_wren) data_q <= mem_ack ? mem_q : 32'hFFFF_FFFF;
            end else begin
              inst_ack  <= 1'b1;
              inst_pend <= 1'b0;
              inst_q    <= mem_ack ? mem_q : 32'hFFFF_FFFF;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_q;
  logic        data_req;
  logic [31:0] data_addr;
  logic [31:0] data_data;
  logic        data_wren;
  logic [3:0]  data_mask;
  logic        data_ack;
  logic [31:0] data_q;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [3:0]  mem_mask;
  logic        mem_ack;
  logic [31:0] mem_q;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ack(inst_ack), .inst_q(inst_q),
    .data_req(data_req), .data_addr(data_addr), .data_data(data_data),
    .data_wren(data_wren), .data_mask(data_mask), .data_ack(data_ack), .data_q(data_q),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_mask(mem_mask), .mem_ack(mem_ack), .mem_q(mem_q), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_data(input logic [31:0] a, input logic [31:0] d,
                           input logic w, input logic [3:0] m);
    data_req = 1'b1; data_addr = a; data_data = d; data_wren = w; data_mask = m;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_addr = '0;
    data_data = '0; data_wren = 1'b0; data_mask = '0; mem_ack = 1'b0; mem_q = '0;
    tick; tick;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_inst_ack", 32'(inst_ack), 32'd0);
    chk("rst_data_ack", 32'(data_ack), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_inst_q", inst_q, 32'd0);
    chk("rst_data_q", data_q, 32'd0);
    chk("rst_mem_mask", 32'(mem_mask), 32'd0);
    reset = 1'b0;
    tick;
    chk("idle_mem_req", 32'(mem_req), 32'd0);

    // Simultaneous pair after reset: data first, then inst
    inst_req = 1'b1; inst_addr = 32'h200;
    send_data(32'h300, 32'h0, 1'b0, 4'hF);
    tick; inst_req = 1'b0; data_req = 1'b0;
    chk("p1_mem_req", 32'(mem_req), 32'd1);
    chk("p1_mem_addr_data", mem_addr, 32'h300);
    chk("p1_mem_wren", 32'(mem_wren), 32'd0);
    mem_ack = 1'b1; mem_q = 32'hAAAA_0001;
    tick; mem_ack = 1'b0;
    chk("p1_data_ack", 32'(data_ack), 32'd1);
    chk("p1_data_q", data_q, 32'hAAAA_0001);
    chk("p1_inst_ack_quiet", 32'(inst_ack), 32'd0);
    chk("p1_mem_req_low", 32'(mem_req), 32'd0);
    tick;
    chk("p1_inst_grant", 32'(mem_req), 32'd1);
    chk("p1_mem_addr_inst", mem_addr, 32'h200);
    chk("p1_inst_mask", 32'(mem_mask), 32'hF);
    chk("p1_inst_mem_data", mem_data, 32'h0);
    chk("p1_data_ack_once", 32'(data_ack), 32'd0);
    mem_ack = 1'b1; mem_q = 32'hBBBB_0002;
    tick; mem_ack = 1'b0;
    chk("p1_inst_ack", 32'(inst_ack), 32'd1);
    chk("p1_inst_q", inst_q, 32'hBBBB_0002);
    chk("p1_data_q_hold", data_q, 32'hAAAA_0001);
    tick;
    chk("p1_idle_mem_req", 32'(mem_req), 32'd0);

    // Data read returning 0x55
    send_data(32'h400, 32'h0, 1'b0, 4'hF);
    tick; data_req = 1'b0;
    chk("rd55_mem_addr", mem_addr, 32'h400);
    mem_ack = 1'b1; mem_q = 32'h55;
    tick; mem_ack = 1'b0;
    chk("rd55_data_q", data_q, 32'h55);

    // Data write: data_q must hold 0x55
    send_data(32'h8000_0000, 32'h41, 1'b1, 4'h1);
    tick; data_req = 1'b0;
    chk("wr_mem_wren", 32'(mem_wren), 32'd1);
    chk("wr_mem_mask", 32'(mem_mask), 32'h1);
    chk("wr_mem_data", mem_data, 32'h41);
    chk("wr_mem_addr", mem_addr, 32'h8000_0000);
    mem_ack = 1'b1; mem_q = 32'hDEAD_BEEF;
    tick; mem_ack = 1'b0;
    chk("wr_data_ack", 32'(data_ack), 32'd1);
    chk("wr_data_q_hold", data_q, 32'h55);

    // Second pair: data was granted last, so inst wins
    inst_req = 1'b1; inst_addr = 32'h210;
    send_data(32'h310, 32'h0, 1'b0, 4'hF);
    tick; inst_req = 1'b0; data_req = 1'b0;
    chk("p2_mem_addr_inst", mem_addr, 32'h210);
    mem_ack = 1'b1; mem_q = 32'hCCCC_0003;
    tick; mem_ack = 1'b0;
    chk("p2_inst_q", inst_q, 32'hCCCC_0003);
    chk("p2_data_ack_quiet", 32'(data_ack), 32'd0);
    tick;
    chk("p2_mem_addr_data", mem_addr, 32'h310);
    mem_ack = 1'b1; mem_q = 32'hDDDD_0004;
    tick; mem_ack = 1'b0;
    chk("p2_data_ack", 32'(data_ack), 32'd1);
    chk("p2_data_q", data_q, 32'hDDDD_0004);

    // Basic fetch with exact latency
    inst_req = 1'b1; inst_addr = 32'h100;
    tick; inst_req = 1'b0;
    chk("v1_mem_req_n1", 32'(mem_req), 32'd1);
    chk("v1_mem_addr", mem_addr, 32'h100);
    chk("v1_mem_mask", 32'(mem_mask), 32'hF);
    tick;
    chk("v1_mem_req_pulse", 32'(mem_req), 32'd0);
    chk("v1_no_early_ack", 32'(inst_ack), 32'd0);
    mem_ack = 1'b1; mem_q = 32'h1234_5678;
    tick; mem_ack = 1'b0;
    chk("v1_inst_ack", 32'(inst_ack), 32'd1);
    chk("v1_inst_q", inst_q, 32'h1234_5678);
    tick;
    chk("v1_inst_ack_pulse", 32'(inst_ack), 32'd0);

    // Requests while pending are ignored, including one in the ack cycle
    inst_req = 1'b1; inst_addr = 32'h500;
    tick;
    chk("v5_mem_req", 32'(mem_req), 32'd1);
    inst_addr = 32'h600;
    tick; inst_req = 1'b0;
    chk("v5_no_second_req", 32'(mem_req), 32'd0);
    chk("v5_addr_kept", mem_addr, 32'h500);
    inst_req = 1'b1; inst_addr = 32'h700; mem_ack = 1'b1; mem_q = 32'h5555_AAAA;
    tick; inst_req = 1'b0; mem_ack = 1'b0;
    chk("v5_inst_ack", 32'(inst_ack), 32'd1);
    chk("v5_inst_q", inst_q, 32'h5555_AAAA);
    tick;
    chk("v5_no_regrant", 32'(mem_req), 32'd0);
    chk("v5_single_ack", 32'(inst_ack), 32'd0);
    tick;
    chk("v5_still_idle", 32'(mem_req), 32'd0);

    // Timeout after 4 WAIT cycles
    send_data(32'h700, 32'h0, 1'b0, 4'hF);
    tick; data_req = 1'b0;
    chk("v4_mem_req", 32'(mem_req), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("v4_wait_no_ack", 32'(data_ack), 32'd0);
      chk("v4_wait_no_err", 32'(bus_err), 32'd0);
    end
    tick;
    chk("v4_data_ack", 32'(data_ack), 32'd1);
    chk("v4_data_q_ones", data_q, 32'hFFFF_FFFF);
    chk("v4_bus_err", 32'(bus_err), 32'd1);
    tick;
    chk("v4_bus_err_pulse", 32'(bus_err), 32'd0);
    mem_ack = 1'b1; mem_q = 32'h9999;
    tick; mem_ack = 1'b0;
    chk("v4_late_ack_ignored", 32'(data_ack), 32'd0);
    chk("v4_late_no_inst_ack", 32'(inst_ack), 32'd0);
    chk("v4_data_q_kept", data_q, 32'hFFFF_FFFF);

    // mem_ack in the timeout cycle wins
    send_data(32'h704, 32'h0, 1'b0, 4'hF);
    tick; data_req = 1'b0;
    chk("tie_mem_req", 32'(mem_req), 32'd1);
    tick; tick; tick;
    mem_ack = 1'b1; mem_q = 32'h77;
    tick; mem_ack = 1'b0;
    chk("tie_data_ack", 32'(data_ack), 32'd1);
    chk("tie_data_q", data_q, 32'h77);
    chk("tie_no_bus_err", 32'(bus_err), 32'd0);

    // Reset during WAIT
    send_data(32'h708, 32'h0, 1'b0, 4'hF);
    tick; data_req = 1'b0;
    chk("v6_mem_addr", mem_addr, 32'h708);
    tick;
    reset = 1'b1;
    #1;
    chk("v6_rst_mem_addr", mem_addr, 32'h0);
    chk("v6_rst_data_q", data_q, 32'h0);
    chk("v6_rst_inst_q", inst_q, 32'h0);
    chk("v6_rst_mem_mask", 32'(mem_mask), 32'h0);
    tick;
    reset = 1'b0;
    mem_ack = 1'b1; mem_q = 32'h1111;
    tick; mem_ack = 1'b0;
    chk("v6_stale_ack", 32'(data_ack), 32'd0);
    chk("v6_stale_mem_req", 32'(mem_req), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("v6_no_ack_after", 32'(data_ack | bus_err), 32'd0);
    end
    inst_req = 1'b1; inst_addr = 32'h900;
    tick; inst_req = 1'b0;
    chk("v6_new_mem_req", 32'(mem_req), 32'd1);
    chk("v6_new_mem_addr", mem_addr, 32'h900);
    mem_ack = 1'b1; mem_q = 32'h2222;
    tick; mem_ack = 1'b0;
    chk("v6_new_inst_ack", 32'(inst_ack), 32'd1);
    chk("v6_new_inst_q", inst_q, 32'h2222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
